ex_div: RTL and testbench

- Iterative radix-2 restoring divider inside the execute stage.
- Consumes DIV.W / DIV.WU / MOD.W / MOD.WU operands from the dispatch-to-execute pipeline register.
- Asserts a pause request to the pipeline controller while it computes. The dispatch-to-execute register and upstream stages hold their contents while the request is high.
- Returns a single-cycle-valid result to the execute-stage result mux.

---
 rtl/pipeline_types.sv | 32 +++
 rtl/div_step.sv | 26 ++
 rtl/ex_div.sv | 138 +++++++++++++
 tb/tb_ex_div.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared execute-pipeline types: divider FSM states and div/mod ALU sub-ops.
// Imported by the decoder, dispatch and the execute-stage divider.
package pipeline_types;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef enum logic [3:0] {
    ALU_DIV_W  = 4'h8,
    ALU_DIV_WU = 4'h9,
    ALU_MOD_W  = 4'ha,
    ALU_MOD_WU = 4'hb
  } alu_div_op_t;

  function automatic logic div_op_signed(
    input alu_div_op_t op
  );
    return (op == ALU_DIV_W) || (op == ALU_MOD_W);
  endfunction

  function automatic logic div_op_mod(
    input alu_div_op_t op
  );
    return (op == ALU_MOD_W) || (op == ALU_MOD_WU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// compare against the divisor and conditionally subtract.
module div_step
  import pipeline_types::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  assign shl  = {rem_i[WIDTH-1:0], bit_i};
  assign diff = shl - {1'b0, dvs_i};

  // The top remainder bit only matters if the partial remainder
  // ever reached 2*divisor, which restoring division never allows.
  assign q_o   = rem_i[WIDTH] | (shl >= {1'b0, dvs_i});
  assign rem_o = q_o ? diff : shl;

endmodule

// File: rtl/ex_div.sv
// Execute-stage iterative radix-2 restoring divider for DIV/MOD(.W/.WU).
// Holds the pipeline via pause_request while iterating.
module ex_div
  import pipeline_types::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ex_stall,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             pause_request
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             mod_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;
  logic [WIDTH:0]   rem_d;
  logic             qbit;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] res_d;
  logic             accept;

  assign mag_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign mag_dvs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(rem_d),
    .q_o  (qbit)
  );

  // Dividend bits shift out of quo_q while quotient bits shift in.
  assign quo_d = {quo_q[WIDTH-2:0], qbit};
  assign r_fin = rem_d[WIDTH-1:0];

  always_comb begin
    res_d = neg_quo_q ? -quo_d : quo_d;
    if (mod_q) begin
      res_d = neg_rem_q ? -r_fin : r_fin;
    end
  end

  assign accept = start && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mod_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= mag_dvd;
            dvs_q     <= mag_dvs;
            mod_q     <= is_mod;
            neg_quo_q <= is_signed &&
                         (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= is_signed && dividend[WIDTH-1];
            if (divisor == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= is_mod ? dividend : '1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= res_d;
          end
        end
        DONE: begin
          if (!ex_stall) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result        = result_q;
  assign done          = done_q;
  assign busy          = (state_q == BUSY);
  assign pause_request = (state_q == IDLE && accept) ||
                         (state_q == BUSY);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed edge cases plus random ops
// checked against an arithmetic reference model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_stall;
  logic        start;
  logic        is_signed;
  logic        is_mod;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        pause_request;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .start        (start),
    .is_signed    (is_signed),
    .is_mod       (is_mod),
    .dividend     (dividend),
    .divisor      (divisor),
    .result       (result),
    .done         (done),
    .busy         (busy),
    .pause_request(pause_request)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s, input logic m);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hffff_ffff;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return m ? r : q;
  endfunction

  // Monitor: compare every done cycle, retire when execute advances.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected done, got %h", result);
      end else begin
        chk("result", result, exp_q[0]);
        if (!ex_stall) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic m);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    is_mod    = m;
    start     = 1'b1;
  endtask

  task automatic wait_done(input int exp_lat, input int stall_n);
    int lat;
    lat = 0;
    #1;
    chk("pause_c0", 32'(pause_request), 32'd1);
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      chk("pause_busy", 32'(pause_request), 32'd1);
      chk("busy", 32'(busy), 32'd1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles, need %0d",
               lat, exp_lat);
      start = 1'b0;
      return;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("pause_done", 32'(pause_request), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    if (stall_n > 0) ex_stall = 1'b1;
    for (int i = 1; i <= stall_n; i++) begin
      @(posedge clk);
      #1;
      chk("done_held", 32'(done), 32'd1);
      chk("busy_held", 32'(busy), 32'd0);
      if (i == stall_n) ex_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic m,
                        input logic [31:0] exp, input int stall_n);
    drive(a, b, s, m);
    exp_q.push_back(exp);
    wait_done((b == 32'd0) ? 1 : 33, stall_n);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        m;
    int          pick;
    int          seen;

    rst = 1'b1;
    flush = 1'b0;
    ex_stall = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    is_mod = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pause", 32'(pause_request), 32'd0);
    rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 0);
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 0);
    run_op(-32'sd7, 32'd2, 1'b1, 1'b0, 32'hffff_fffd, 0);
    run_op(-32'sd7, 32'd2, 1'b1, 1'b1, 32'hffff_ffff, 0);
    run_op(32'd7, -32'sd2, 1'b1, 1'b1, 32'd1, 0);
    run_op(32'h8000_0000, 32'hffff_ffff, 1'b1, 1'b0, 32'h8000_0000, 0);
    run_op(32'h8000_0000, 32'hffff_ffff, 1'b1, 1'b1, 32'd0, 0);
    run_op(32'h1234, 32'd0, 1'b0, 1'b0, 32'hffff_ffff, 0);
    run_op(32'h1234, 32'd0, 1'b0, 1'b1, 32'h1234, 0);
    run_op(32'hffff_fff0, 32'd0, 1'b1, 1'b0, 32'hffff_ffff, 0);
    run_op(32'hffff_fff0, 32'd0, 1'b1, 1'b1, 32'hffff_fff0, 0);

    // Flush in BUSY cycle 10 abandons the op.
    drive(32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_idle", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("flush_quiet", 32'(seen), 32'd0);
    run_op(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 0);

    // Start coinciding with flush in IDLE is ignored.
    drive(32'd50, 32'd5, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_start_pause", 32'(pause_request), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);

    run_op(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 5);

    // Reset mid-BUSY with start held through it.
    drive(32'd77, 32'd7, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_result", result, 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_pause", 32'(pause_request), 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_busy2", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_q.push_back(32'd11);
    wait_done(33, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hffff_ffff;
        3: begin
          a = 32'h8000_0000;
          b = 32'hffff_ffff;
        end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      run_op(a, b, s, m, model(a, b, s, m), $urandom_range(0, 2));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
